// File: rtl/blake2s_block_sched.sv
// Block scheduler: packs kk key bytes and ll message bytes into zero-padded 64-byte BLAKE2s blocks.
// Keyed mode is built only when BLAKE2S_SCHED_KEY_EN is defined; otherwise kk must be 0.
module blake2s_block_sched #(
  parameter int GAP_CYCLES = 24,
  parameter int LL_W       = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start_i,
  input  logic [6:0]      kk_i,
  input  logic [6:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  input  logic            in_v_i,
  input  logic [7:0]      in_data_i,
  output logic            in_ready_o,
  output logic [6:0]      kk_o,
  output logic [6:0]      nn_o,
  output logic [LL_W-1:0] ll_o,
  output logic            data_v_o,
  output logic [7:0]      data_o,
  output logic [5:0]      data_idx_o,
  output logic            block_first_o,
  output logic            block_last_o,
  input  logic            finished_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            cfg_err_o
);

  // state | meaning
  // IDLE  | waiting for start
  // KEY   | accepting key bytes
  // MSG   | accepting message bytes
  // PAD   | emitting zero bytes up to idx 63
  // GAP   | idling while the core compresses
  // WAIT  | all blocks sent, waiting for finished_i
  // DONE  | complete, configuration held
  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_MSG, S_PAD, S_GAP, S_WAIT, S_DONE
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t state, state_nxt, first_state, after_blk;

  logic [6:0]      nn_q;
  logic [LL_W-1:0] ll_q;
  logic [LL_W-1:0] rem;
  logic [LL_W-1:0] blk;
  logic [LL_W-1:0] nb_last;
  logic [LL_W-1:0] nb_msg;
  logic [LL_W-1:0] nb_last_nxt;
  logic [5:0]      idx;
  logic [GW-1:0]   gap_cnt;

  logic idle_or_done, cfg_bad, start_ok, start_bad;
  logic accept, emit, is_last;

`ifdef BLAKE2S_SCHED_KEY_EN
  logic [6:0] kk_q;
  logic [5:0] key_rem;

  assign cfg_bad    = (kk_i > 7'd32) || (nn_i == 7'd0) || (nn_i > 7'd32);
  assign in_ready_o = (state == S_KEY) || (state == S_MSG);
  assign kk_o       = kk_q;
`else
  assign cfg_bad    = (kk_i != 7'd0) || (nn_i == 7'd0) || (nn_i > 7'd32);
  assign in_ready_o = (state == S_MSG);
  assign kk_o       = 7'd0;
`endif

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_ok     = start_i && idle_or_done && !cfg_bad;
  assign start_bad    = start_i && idle_or_done && cfg_bad;

  assign accept  = in_v_i && in_ready_o;
  assign emit    = accept || (state == S_PAD);
  assign is_last = (blk == nb_last);

  assign busy_o = !idle_or_done;
  assign done_o = (state == S_DONE);
  assign nn_o   = nn_q;
  assign ll_o   = ll_q;

  // message blocks = ceil(ll/64); an empty unkeyed hash still sends one block
  assign nb_msg = (ll_i >> 6) + LL_W'(ll_i[5:0] != 6'd0);

  always_comb begin
    first_state = (ll_i != '0) ? S_MSG : S_PAD;
    nb_last_nxt = (nb_msg == '0) ? '0 : nb_msg - LL_W'(1);
`ifdef BLAKE2S_SCHED_KEY_EN
    if (kk_i != 7'd0) begin
      first_state = S_KEY;
      nb_last_nxt = nb_msg;
    end
`endif
  end

  always_comb begin
    after_blk = S_GAP;
    if (is_last) after_blk = S_WAIT;
    else if (GAP_CYCLES == 0) after_blk = S_MSG;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = first_state;
`ifdef BLAKE2S_SCHED_KEY_EN
      S_KEY: if (accept && key_rem == 6'd1) state_nxt = S_PAD;
`endif
      S_MSG: begin
        if (accept) begin
          if (idx == 6'd63) state_nxt = after_blk;
          else if (rem == LL_W'(1)) state_nxt = S_PAD;
        end
      end
      S_PAD:  if (idx == 6'd63) state_nxt = after_blk;
      S_GAP:  if (gap_cnt == '0) state_nxt = S_MSG;
      S_WAIT: if (finished_i) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      data_v_o      <= 1'b0;
      data_o        <= 8'd0;
      data_idx_o    <= 6'd0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      cfg_err_o     <= 1'b0;
      nn_q          <= 7'd0;
      ll_q          <= '0;
      rem           <= '0;
      blk           <= '0;
      nb_last       <= '0;
      idx           <= 6'd0;
      gap_cnt       <= GAP_LOAD;
`ifdef BLAKE2S_SCHED_KEY_EN
      kk_q          <= 7'd0;
      key_rem       <= 6'd0;
`endif
    end else begin
      data_v_o  <= emit;
      cfg_err_o <= start_bad;
      if (emit) begin
        data_o        <= (state == S_PAD) ? 8'd0 : in_data_i;
        data_idx_o    <= idx;
        block_first_o <= (blk == '0);
        block_last_o  <= is_last;
        idx           <= idx + 6'd1;
        if (idx == 6'd63) blk <= blk + LL_W'(1);
      end
      if (state == S_MSG && accept) rem <= rem - LL_W'(1);
`ifdef BLAKE2S_SCHED_KEY_EN
      if (state == S_KEY && accept) key_rem <= key_rem - 6'd1;
`endif
      if (state == S_GAP) gap_cnt <= gap_cnt - GW'(1);
      else                gap_cnt <= GAP_LOAD;
      if (start_ok) begin
        nn_q    <= nn_i;
        ll_q    <= ll_i;
        rem     <= ll_i;
        nb_last <= nb_last_nxt;
        blk     <= '0;
        idx     <= 6'd0;
`ifdef BLAKE2S_SCHED_KEY_EN
        kk_q    <= kk_i;
        key_rem <= kk_i[5:0];
`endif
      end
    end
  end

endmodule
